// File: rtl/cpu_pkg.sv
// Shared fetch-path types: the NOP used for empty decode slots and the
// {pc, instr} entry carried through the prefetch queue.
package cpu_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;  // addi x0,x0,0

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fq_fifo.sv
// Circular buffer of fetch entries with occupancy count and a synchronous
// flush that empties it. DEPTH must be a power of two so pointers wrap freely.
module fq_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     wr_en,
  input  fetch_entry_t             wr_data,
  input  logic                     rd_en,
  output fetch_entry_t             rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  fetch_entry_t  mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: owns the fetch PC, issues credit-limited reads
// to a 1-cycle instruction memory and buffers {pc, instr} for the ID stage.
// Optional FETCH_BYPASS_EN forwards a response straight to ID when the queue is empty.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]  fetch_pc;
  logic [31:0]  rsp_pc;
  logic         rsp_pending;
  logic [CW-1:0] count;
  fetch_entry_t head;
  fetch_entry_t rsp_entry;
  logic         empty;
  logic         credit;
  logic         issue;
  logic         bypass_valid;
  logic         bypass_take;
  logic         wr_en;
  logic         rd_en;

  assign empty = (count == '0);

  // The in-flight response already owns a slot, so it is charged against the
  // credit; a dequeue in the same cycle is deliberately not credited back.
  assign credit = (count + CW'(rsp_pending)) < CW'(DEPTH);
  assign issue  = reset && credit && !redirect;

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign rsp_entry = '{pc: rsp_pc, instr: imem_rdata};

  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= '0;
      rsp_pending <= 1'b0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc;
      rsp_pending <= 1'b0;
    end else begin
      rsp_pending <= issue;
      if (issue) begin
        fetch_pc <= fetch_pc + 32'd4;
        rsp_pc   <= fetch_pc;
      end
    end
  end

`ifdef FETCH_BYPASS_EN
  assign bypass_valid = empty && rsp_pending && !redirect;
  assign bypass_take  = bypass_valid && id_ready;

  always_comb begin
    id_valid = 1'b0;
    id_instr = NOP_INSTR;
    id_pc    = '0;
    if (!empty) begin
      id_valid = 1'b1;
      id_instr = head.instr;
      id_pc    = head.pc;
    end else if (bypass_valid) begin
      id_valid = 1'b1;
      id_instr = rsp_entry.instr;
      id_pc    = rsp_entry.pc;
    end
  end
`else
  assign bypass_valid = 1'b0;
  assign bypass_take  = 1'b0;

  always_comb begin
    id_valid = 1'b0;
    id_instr = NOP_INSTR;
    id_pc    = '0;
    if (!empty) begin
      id_valid = 1'b1;
      id_instr = head.instr;
      id_pc    = head.pc;
    end
  end
`endif

  // Redirect voids both the pending write and any dequeue; the flush wins.
  assign wr_en = rsp_pending && !redirect && !bypass_take;
  assign rd_en = !empty && id_ready && !redirect;

  fq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (redirect),
    .wr_en   (wr_en),
    .wr_data (rsp_entry),
    .rd_en   (rd_en),
    .rd_data (head),
    .count   (count)
  );

endmodule
